psr_bcond_unit: RTL and testbench
=================================

Name: psr_bcond_unit

Overview:
- Downstream neighbour of the ALU stage: captures the ALU's 16-bit psr_flags output into the architectural Processor Status Register (PSR).
- Gates each flag update by instruction class.
- Evaluates 4-bit branch/jump condition codes (Bcond/Jcond) against the PSR.
- Hands a registered taken/target decision to the fetch stage through a valid/ready handshake.

Parameters:
- WIDTH, 16, datapath and PC width
- ALU_CONT_BITS, 6, width of the ALU control code

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- alu_valid  input  1  ALU result this cycle is a committed instruction
- alu_cont  input  ALU_CONT_BITS  control code of that instruction
- psr_flags  input  WIDTH  ALU flag word {8'b0,N,Z,F,2'b0,L,1'b0,C}
- psr_wr_en  input  1  explicit PSR write (LPR-class instruction)
- psr_wr_data  input  WIDTH  data for explicit write
- psr  output  WIDTH  current PSR, same bit layout as psr_flags
- br_valid  input  1  branch request present
- br_ready  output  1  unit accepts branch request this cycle
- br_cond  input  4  condition code
- br_target  input  WIDTH  taken target
- br_pc_plus1  input  WIDTH  fall-through PC
- flush  input  1  discard any held decision
- out_valid  output  1  decision held for fetch
- out_ready  input  1  fetch consumes decision
- out_taken  output  1  condition was true
- out_pc  output  WIDTH  next PC (br_target if taken, else br_pc_plus1)

Behaviour:
- Reset: psr=0, out_valid=0, out_taken=0, out_pc=0. Reset overrides all other inputs in the same cycle, including mid-handshake.
- PSR storage: only bits 0(C), 2(L), 5(F), 6(Z), 7(N) are writable; all other bits read 0 always.
- PSR write priority per cycle: reset > psr_wr_en > ALU update.
- ALU update applies only when alu_valid=1. The mask depends on alu_cont:
  - 000101 (ADD/ADDI): C,F
  - 001001 (SUB/SUBI): C,F
  - 001011 (CMP/CMPI): N,Z,L
  - all other codes: no change
- Unmasked flags retain their value.
- psr_wr_en writes all five flags from psr_wr_data in one cycle.
- Condition evaluation (f = effective flags):
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 HI: L
  - 5 LS: !L
  - 6 GT: N
  - 7 LE: !N
  - 8 FS: F
  - 9 FC: !F
  - A LO: !L&!Z
  - B HS: L|Z
  - C LT: !N&!Z
  - D GE: N|Z
  - E UC: 1
  - F NV: 0
- Handshake:
  - br_ready = !out_valid | out_ready (combinational, single-entry output register).
  - Accept when br_valid & br_ready.
  - On accept, out_* load next cycle (latency 1) and out_valid=1.
  - out_valid clears when out_ready=1 and there is no new accept.
  - Simultaneous consume and accept keeps out_valid=1 with the new data.
  - Held out_* stay stable while out_valid & !out_ready.
- flush=1: out_valid<=0 next cycle, and br_ready is forced 0 that cycle, so nothing is accepted.
- Arithmetic: no arithmetic; target selection only, no truncation.

Optional Feature:
- PSR_BYPASS_EN
  - Defined: effective flags = the value the PSR will hold after this cycle's write, so a CMP and Bcond in the same cycle see the new CMP flags.
  - Undefined: effective flags = registered psr only. Additionally, br_ready is forced 0 in any cycle where a PSR write (psr_wr_en, or alu_valid with a non-empty mask) occurs, so a branch never evaluates stale flags.

Decomposition:
- Shared package holds:
  - condition-code constants COND_EQ..COND_NV
  - PSR bit indices PSR_C=0, PSR_L=2, PSR_F=5, PSR_Z=6, PSR_N=7
  - ALU control constants ALU_ADD=6'b000101, ALU_SUB=6'b001001, ALU_CMP=6'b001011
- Sub-module cond_eval: purely combinational (flags, cond) -> taken. It is reused by the Jcond/Scond paths.

Test Plan:
- reset asserted while out_valid=1 and psr=16'h00E5 -> next cycle psr=0, out_valid=0, out_pc=0.
- alu_valid, alu_cont=001011, psr_flags=16'h0044 -> psr=16'h0044. Then alu_cont=000101, psr_flags=16'h00A1 -> psr=16'h0065 (Z,L kept; F,C set; N unchanged at 0).
- psr Z=1; br_valid, cond=0, target=16'h0040, pc_plus1=16'h0011 -> one cycle later out_valid=1, out_taken=1, out_pc=16'h0040. Same with cond=1 -> out_taken=0, out_pc=16'h0011.
- out_ready=0 for 3 cycles with br_valid held -> br_ready=0, out_pc stable. Then out_ready=1 with new br_valid -> back-to-back transfer, no bubble.
- Same-cycle CMP (Z becomes 1) and EQ branch:
  - with PSR_BYPASS_EN: taken, accepted that cycle.
  - without: br_ready=0 that cycle; accepted next cycle, taken.
- psr_wr_en with psr_wr_data=16'hFFFF concurrent with alu_valid ADD -> psr=16'h00E5; cond=F never taken; cond=E always taken; flush while out_valid=1 -> out_valid=0 next cycle.

Source files
------------

// File: rtl/psr_bcond_unit_pkg.sv
// Shared constants and types for the PSR / branch-condition unit and its condition evaluator.
package psr_bcond_unit_pkg;

  localparam int PSR_C = 0;
  localparam int PSR_L = 2;
  localparam int PSR_F = 5;
  localparam int PSR_Z = 6;
  localparam int PSR_N = 7;

  localparam logic [5:0] ALU_ADD = 6'b000101;
  localparam logic [5:0] ALU_SUB = 6'b001001;
  localparam logic [5:0] ALU_CMP = 6'b001011;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_HI = 4'h4,
    COND_LS = 4'h5,
    COND_GT = 4'h6,
    COND_LE = 4'h7,
    COND_FS = 4'h8,
    COND_FC = 4'h9,
    COND_LO = 4'hA,
    COND_HS = 4'hB,
    COND_LT = 4'hC,
    COND_GE = 4'hD,
    COND_UC = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  // Compact form of the five architecturally writable PSR bits.
  typedef struct packed {
    logic n;
    logic z;
    logic f;
    logic l;
    logic c;
  } flags_t;

endpackage

// File: rtl/psr_bcond_unit_if.sv
// ALU-result, PSR-write, branch-request and fetch-decision signals of psr_bcond_unit.
interface psr_bcond_unit_if #(
  parameter int WIDTH         = 16,
  parameter int ALU_CONT_BITS = 6
);
  logic                     alu_valid;
  logic [ALU_CONT_BITS-1:0] alu_cont;
  logic [WIDTH-1:0]         psr_flags;
  logic                     psr_wr_en;
  logic [WIDTH-1:0]         psr_wr_data;
  logic [WIDTH-1:0]         psr;
  logic                     br_valid;
  logic                     br_ready;
  logic [3:0]               br_cond;
  logic [WIDTH-1:0]         br_target;
  logic [WIDTH-1:0]         br_pc_plus1;
  logic                     flush;
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_taken;
  logic [WIDTH-1:0]         out_pc;

  modport master (
    output alu_valid, alu_cont, psr_flags, psr_wr_en, psr_wr_data,
    output br_valid, br_cond, br_target, br_pc_plus1, flush, out_ready,
    input  psr, br_ready, out_valid, out_taken, out_pc
  );

  modport slave (
    input  alu_valid, alu_cont, psr_flags, psr_wr_en, psr_wr_data,
    input  br_valid, br_cond, br_target, br_pc_plus1, flush, out_ready,
    output psr, br_ready, out_valid, out_taken, out_pc
  );
endinterface

// File: rtl/psr_bcond_unit_cond_eval.sv
// Combinational Bcond/Jcond/Scond condition evaluator: (flags, cond) -> taken.
module psr_bcond_unit_cond_eval
  import psr_bcond_unit_pkg::*;
(
  input  flags_t     flags,
  input  logic [3:0] cond,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (cond_e'(cond))
      COND_EQ: taken = flags.z;
      COND_NE: taken = !flags.z;
      COND_CS: taken = flags.c;
      COND_CC: taken = !flags.c;
      COND_HI: taken = flags.l;
      COND_LS: taken = !flags.l;
      COND_GT: taken = flags.n;
      COND_LE: taken = !flags.n;
      COND_FS: taken = flags.f;
      COND_FC: taken = !flags.f;
      COND_LO: taken = !flags.l && !flags.z;
      COND_HS: taken = flags.l || flags.z;
      COND_LT: taken = !flags.n && !flags.z;
      COND_GE: taken = flags.n || flags.z;
      COND_UC: taken = 1'b1;
      COND_NV: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/psr_bcond_unit.sv
// PSR capture with per-class flag masking, plus a registered branch decision handed to fetch.
// Build option PSR_BYPASS_EN: branches see this cycle's PSR write instead of stalling on it.
module psr_bcond_unit
  import psr_bcond_unit_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int ALU_CONT_BITS = 6
) (
  input logic            clk,
  input logic            reset,
  psr_bcond_unit_if.slave bus
);

  flags_t           psr_q;
  flags_t           psr_nxt;
  flags_t           alu_f;
  flags_t           wr_f;
  flags_t           alu_mask;
  flags_t           eff_flags;
  logic             taken;
  logic             accept;
  logic             br_ready_int;
  logic             stall_wr;
  logic             out_valid_q;
  logic             out_taken_q;
  logic [WIDTH-1:0] out_pc_q;
  logic [WIDTH-1:0] psr_word;
  logic             unused_bits;

  assign alu_f = '{n: bus.psr_flags[PSR_N], z: bus.psr_flags[PSR_Z], f: bus.psr_flags[PSR_F],
                   l: bus.psr_flags[PSR_L], c: bus.psr_flags[PSR_C]};
  assign wr_f  = '{n: bus.psr_wr_data[PSR_N], z: bus.psr_wr_data[PSR_Z], f: bus.psr_wr_data[PSR_F],
                   l: bus.psr_wr_data[PSR_L], c: bus.psr_wr_data[PSR_C]};

  // Only committed ADD/SUB/CMP touch flags; everything else leaves the PSR alone.
  always_comb begin
    alu_mask = '0;
    if (bus.alu_valid) begin
      case (bus.alu_cont)
        ALU_CONT_BITS'(ALU_ADD),
        ALU_CONT_BITS'(ALU_SUB): begin
          alu_mask.c = 1'b1;
          alu_mask.f = 1'b1;
        end
        ALU_CONT_BITS'(ALU_CMP): begin
          alu_mask.n = 1'b1;
          alu_mask.z = 1'b1;
          alu_mask.l = 1'b1;
        end
        default: alu_mask = '0;
      endcase
    end
  end

  always_comb begin
    if (bus.psr_wr_en) psr_nxt = wr_f;
    else               psr_nxt = flags_t'((psr_q & ~alu_mask) | (alu_f & alu_mask));
  end

`ifdef PSR_BYPASS_EN
  assign eff_flags = psr_nxt;
  assign stall_wr  = 1'b0;
`else
  assign eff_flags = psr_q;
  assign stall_wr  = bus.psr_wr_en | (|alu_mask);
`endif

  psr_bcond_unit_cond_eval u_cond_eval (
    .flags (eff_flags),
    .cond  (bus.br_cond),
    .taken (taken)
  );

  assign br_ready_int = (!out_valid_q || bus.out_ready) && !bus.flush && !stall_wr;
  assign accept       = bus.br_valid && br_ready_int;

  always_ff @(posedge clk) begin
    if (reset) begin
      psr_q       <= '0;
      out_valid_q <= 1'b0;
      out_taken_q <= 1'b0;
      out_pc_q    <= '0;
    end else begin
      psr_q <= psr_nxt;
      if (bus.flush) begin
        out_valid_q <= 1'b0;
      end else if (accept) begin
        out_valid_q <= 1'b1;
        out_taken_q <= taken;
        out_pc_q    <= taken ? bus.br_target : bus.br_pc_plus1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    psr_word        = '0;
    psr_word[PSR_C] = psr_q.c;
    psr_word[PSR_L] = psr_q.l;
    psr_word[PSR_F] = psr_q.f;
    psr_word[PSR_Z] = psr_q.z;
    psr_word[PSR_N] = psr_q.n;
  end

  // Non-flag bits of the incoming words are architecturally ignored.
  assign unused_bits = ^{bus.psr_flags, bus.psr_wr_data};

  assign bus.psr       = psr_word;
  assign bus.br_ready  = br_ready_int;
  assign bus.out_valid = out_valid_q;
  assign bus.out_taken = out_taken_q;
  assign bus.out_pc    = out_pc_q;

endmodule

// File: tb/tb_psr_bcond_unit.sv
// Self-checking bench for psr_bcond_unit: vector tables, hand sequences and a decision scoreboard.
module tb_psr_bcond_unit;
  import psr_bcond_unit_pkg::*;

`ifdef PSR_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  psr_bcond_unit_if #(.WIDTH(16), .ALU_CONT_BITS(6)) bus ();

  psr_bcond_unit #(.WIDTH(16), .ALU_CONT_BITS(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        taken;
    logic [15:0] pc;
  } exp_t;
  exp_t sb[$];

  logic [15:0] m_psr;
  logic        m_ov;

  typedef struct {
    logic        av;
    logic [5:0]  cont;
    logic [15:0] flags;
    logic        wr;
    logic [15:0] wd;
    logic [15:0] exp_psr;
  } psr_vec_t;

  typedef struct {
    logic [15:0] psr_val;
    logic [3:0]  cond;
    logic        exp_taken;
  } cond_vec_t;

  psr_vec_t pv[11] = '{
    '{1'b1, 6'b001011, 16'h0044, 1'b0, 16'h0000, 16'h0044},
    '{1'b1, 6'b000101, 16'h00A1, 1'b0, 16'h0000, 16'h0065},
    '{1'b1, 6'b001001, 16'h0000, 1'b0, 16'h0000, 16'h0044},
    '{1'b1, 6'b000000, 16'hFFFF, 1'b0, 16'h0000, 16'h0044},
    '{1'b0, 6'b001011, 16'h0080, 1'b0, 16'h0000, 16'h0044},
    '{1'b1, 6'b001011, 16'hFFFF, 1'b0, 16'h0000, 16'h00C4},
    '{1'b1, 6'b000101, 16'h0000, 1'b1, 16'hFFFF, 16'h00E5},
    '{1'b0, 6'b000000, 16'h0000, 1'b1, 16'h0000, 16'h0000},
    '{1'b1, 6'b001001, 16'hFFFF, 1'b0, 16'h0000, 16'h0021},
    '{1'b0, 6'b000000, 16'h0000, 1'b1, 16'h1234, 16'h0024},
    '{1'b1, 6'b000101, 16'h0000, 1'b0, 16'h0000, 16'h0004}
  };

  cond_vec_t cv[22] = '{
    '{16'h0040, 4'h0, 1'b1}, '{16'h0000, 4'h0, 1'b0},
    '{16'h0040, 4'h1, 1'b0}, '{16'h0000, 4'h1, 1'b1},
    '{16'h0001, 4'h2, 1'b1}, '{16'h0001, 4'h3, 1'b0},
    '{16'h0004, 4'h4, 1'b1}, '{16'h0004, 4'h5, 1'b0},
    '{16'h0080, 4'h6, 1'b1}, '{16'h0080, 4'h7, 1'b0},
    '{16'h0020, 4'h8, 1'b1}, '{16'h0020, 4'h9, 1'b0},
    '{16'h0000, 4'hA, 1'b1}, '{16'h0004, 4'hA, 1'b0},
    '{16'h0040, 4'hB, 1'b1}, '{16'h0000, 4'hB, 1'b0},
    '{16'h0000, 4'hC, 1'b1}, '{16'h0080, 4'hC, 1'b0},
    '{16'h0040, 4'hD, 1'b1}, '{16'h0000, 4'hD, 1'b0},
    '{16'h0000, 4'hE, 1'b1}, '{16'h00E5, 4'hF, 1'b0}
  };

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Truth table of all 16 conditions, bit k = condition code k.
  function automatic logic model_cond(input logic [15:0] f, input logic [3:0] c);
    logic [15:0] tv;
    logic n, z, fl, l, cy;
    n = f[7]; z = f[6]; fl = f[5]; l = f[2]; cy = f[0];
    tv = {1'b0, 1'b1, n | z, !n & !z, l | z, !l & !z, !fl, fl,
          !n, n, !l, l, !cy, cy, !z, z};
    return tv[c];
  endfunction

  function automatic logic [15:0] model_mask(input logic av, input logic [5:0] cont);
    if (!av) return 16'h0000;
    if (cont == 6'b000101 || cont == 6'b001001) return 16'h0021;
    if (cont == 6'b001011) return 16'h00C4;
    return 16'h0000;
  endfunction

  // Reference model + scoreboard, sampled on every rising edge.
  initial begin
    logic [15:0] nxt, eff, mask;
    logic        rdy, evt;
    exp_t        e;
    m_psr = 16'h0000;
    m_ov  = 1'b0;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_psr = 16'h0000;
        m_ov  = 1'b0;
        sb.delete();
      end else begin
        chk("psr_model", bus.psr, m_psr);
        chk("out_valid_model", bus.out_valid, m_ov);
        mask = model_mask(bus.alu_valid, bus.alu_cont);
        if (bus.psr_wr_en) nxt = bus.psr_wr_data & 16'h00E5;
        else               nxt = (m_psr & ~mask) | (bus.psr_flags & mask);
        evt = bus.psr_wr_en | (mask != 16'h0000);
        eff = BYPASS ? nxt : m_psr;
        rdy = (!m_ov | bus.out_ready) & !bus.flush & (BYPASS | !evt);
        if (bus.br_valid) chk("br_ready_model", bus.br_ready, rdy);
        if (m_ov && bus.flush) begin
          if (sb.size() > 0) void'(sb.pop_front());
        end else if (m_ov && bus.out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: got decision, expected none (t=%0t)", $time);
          end else begin
            e = sb.pop_front();
            chk("sb_taken", bus.out_taken, e.taken);
            chk("sb_pc", bus.out_pc, e.pc);
          end
        end
        if (bus.br_valid && rdy) begin
          e.taken = model_cond(eff, bus.br_cond);
          e.pc    = e.taken ? bus.br_target : bus.br_pc_plus1;
          sb.push_back(e);
        end
        if (bus.flush)                   m_ov = 1'b0;
        else if (bus.br_valid && rdy)    m_ov = 1'b1;
        else if (bus.out_ready)          m_ov = 1'b0;
        m_psr = nxt;
      end
    end
  end

  task automatic idle();
    bus.alu_valid   = 1'b0;
    bus.alu_cont    = 6'b000000;
    bus.psr_flags   = 16'h0000;
    bus.psr_wr_en   = 1'b0;
    bus.psr_wr_data = 16'h0000;
    bus.br_valid    = 1'b0;
    bus.br_cond     = 4'h0;
    bus.br_target   = 16'h0000;
    bus.br_pc_plus1 = 16'h0000;
    bus.flush       = 1'b0;
    bus.out_ready   = 1'b1;
  endtask

  task automatic write_psr(input logic [15:0] v);
    bus.psr_wr_en   = 1'b1;
    bus.psr_wr_data = v;
    tick();
    bus.psr_wr_en   = 1'b0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    chk("reset_psr", bus.psr, 16'h0000);
    chk("reset_out_valid", bus.out_valid, 1'b0);
    chk("reset_out_pc", bus.out_pc, 16'h0000);
    chk("reset_out_taken", bus.out_taken, 1'b0);

    for (int i = 0; i < 11; i++) begin
      bus.alu_valid   = pv[i].av;
      bus.alu_cont    = pv[i].cont;
      bus.psr_flags   = pv[i].flags;
      bus.psr_wr_en   = pv[i].wr;
      bus.psr_wr_data = pv[i].wd;
      tick();
      chk($sformatf("psr_vec%0d", i), bus.psr, pv[i].exp_psr);
    end
    idle();

    for (int i = 0; i < 22; i++) begin
      write_psr(cv[i].psr_val);
      bus.br_valid    = 1'b1;
      bus.br_cond     = cv[i].cond;
      bus.br_target   = 16'h0040;
      bus.br_pc_plus1 = 16'h0011;
      tick();
      bus.br_valid = 1'b0;
      chk($sformatf("cond%0d_valid", i), bus.out_valid, 1'b1);
      chk($sformatf("cond%0d_taken", i), bus.out_taken, cv[i].exp_taken);
      chk($sformatf("cond%0d_pc", i), bus.out_pc, cv[i].exp_taken ? 16'h0040 : 16'h0011);
      tick();
    end

    // Backpressure: held decision stays stable, then back-to-back transfer.
    bus.br_valid    = 1'b1;
    bus.br_cond     = 4'hE;
    bus.br_target   = 16'h0100;
    bus.br_pc_plus1 = 16'h0101;
    bus.out_ready   = 1'b0;
    tick();
    chk("bp_valid", bus.out_valid, 1'b1);
    bus.br_target   = 16'h0200;
    bus.br_pc_plus1 = 16'h0201;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready_low", bus.br_ready, 1'b0);
      chk("bp_pc_stable", bus.out_pc, 16'h0100);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_ready_high", bus.br_ready, 1'b1);
    tick();
    chk("b2b_valid", bus.out_valid, 1'b1);
    chk("b2b_pc", bus.out_pc, 16'h0200);
    bus.br_valid = 1'b0;
    tick();
    chk("b2b_drain", bus.out_valid, 1'b0);

    // Same-cycle CMP setting Z and an EQ branch.
    write_psr(16'h0000);
    bus.alu_valid   = 1'b1;
    bus.alu_cont    = 6'b001011;
    bus.psr_flags   = 16'h0040;
    bus.br_valid    = 1'b1;
    bus.br_cond     = 4'h0;
    bus.br_target   = 16'h0077;
    bus.br_pc_plus1 = 16'h0078;
    #1;
`ifdef PSR_BYPASS_EN
    chk("cmp_eq_ready", bus.br_ready, 1'b1);
    tick();
    bus.alu_valid = 1'b0;
    chk("cmp_eq_valid", bus.out_valid, 1'b1);
    chk("cmp_eq_taken", bus.out_taken, 1'b1);
    chk("cmp_eq_pc", bus.out_pc, 16'h0077);
`else
    chk("cmp_eq_stall", bus.br_ready, 1'b0);
    tick();
    bus.alu_valid = 1'b0;
    chk("cmp_eq_not_yet", bus.out_valid, 1'b0);
    #1;
    chk("cmp_eq_ready", bus.br_ready, 1'b1);
    tick();
    chk("cmp_eq_valid", bus.out_valid, 1'b1);
    chk("cmp_eq_taken", bus.out_taken, 1'b1);
    chk("cmp_eq_pc", bus.out_pc, 16'h0077);
`endif
    bus.br_valid = 1'b0;
    tick();

    // Flush discards a held decision and blocks acceptance that cycle.
    bus.br_valid    = 1'b1;
    bus.br_cond     = 4'hE;
    bus.br_target   = 16'h0300;
    bus.br_pc_plus1 = 16'h0301;
    bus.out_ready   = 1'b0;
    tick();
    chk("flush_pre_valid", bus.out_valid, 1'b1);
    bus.flush = 1'b1;
    #1;
    chk("flush_ready", bus.br_ready, 1'b0);
    tick();
    chk("flush_valid", bus.out_valid, 1'b0);
    bus.flush     = 1'b0;
    bus.br_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("flush_stays_idle", bus.out_valid, 1'b0);

    // Reset mid-handshake with a full PSR.
    write_psr(16'hFFFF);
    bus.br_valid    = 1'b1;
    bus.br_cond     = 4'hE;
    bus.br_target   = 16'h0400;
    bus.br_pc_plus1 = 16'h0401;
    bus.out_ready   = 1'b0;
    tick();
    chk("pre_reset_psr", bus.psr, 16'h00E5);
    chk("pre_reset_valid", bus.out_valid, 1'b1);
    reset = 1'b1;
    tick();
    chk("mid_reset_psr", bus.psr, 16'h0000);
    chk("mid_reset_valid", bus.out_valid, 1'b0);
    chk("mid_reset_pc", bus.out_pc, 16'h0000);
    chk("mid_reset_taken", bus.out_taken, 1'b0);
    reset = 1'b0;
    idle();
    tick();
    tick();
    chk("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
